// File: rtl/sdrc_arb_pkg.sv
// Shared types for the multi-port SDRAM request arbiter.
// Port ids are sized for the largest supported port count (8).
package sdrc_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WR} arb_state_e;

  localparam int MAX_PORTS = 8;
  localparam int PID_W     = $clog2(MAX_PORTS);

  typedef logic [PID_W-1:0] pid_t;

  function automatic pid_t pid_inc(input pid_t p, input int n);
    return (int'(p) + 1 >= n) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sdrc_arb_tagq.sv
// Port-tag FIFO recording which port owns each outstanding read burst.
// Head is the owner of the read data currently returned by the core.
module sdrc_arb_tagq
  import sdrc_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  pid_t push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output pid_t head
);

  localparam int AW = $clog2(DEPTH);

  pid_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdrc_mport_arb.sv
// N-port round-robin arbiter in front of one sdrc_core app interface.
// Optional build macro SDRC_ARB_PRIO_EN makes port 0 strict high priority.
module sdrc_mport_arb
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int APP_AW    = 26,
  parameter int APP_DW    = 32,
  parameter int APP_BW    = 4,
  parameter int BL        = 9,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_resetn,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS*APP_AW-1:0] p_req_addr,
  input  logic [NUM_PORTS*BL-1:0]     p_req_len,
  input  logic [NUM_PORTS-1:0]        p_req_wr_n,
  output logic [NUM_PORTS-1:0]        p_req_ack,
  input  logic [NUM_PORTS*APP_DW-1:0] p_wr_data,
  input  logic [NUM_PORTS*APP_BW-1:0] p_wr_en_n,
  output logic [NUM_PORTS-1:0]        p_wr_next,
  output logic [APP_DW-1:0]           p_rd_data,
  output logic [NUM_PORTS-1:0]        p_rd_valid,
  output logic [NUM_PORTS-1:0]        p_last_rd,
  output logic                        app_req,
  output logic [APP_AW-1:0]           app_req_addr,
  output logic [BL-1:0]               app_req_len,
  output logic                        app_req_wr_n,
  input  logic                        app_req_ack,
  output logic [APP_DW-1:0]           app_wr_data,
  output logic [APP_BW-1:0]           app_wr_en_n,
  input  logic                        app_wr_next_req,
  input  logic                        app_last_wr,
  input  logic [APP_DW-1:0]           app_rd_data,
  input  logic                        app_rd_valid,
  input  logic                        app_last_rd
);

  arb_state_e          r_state;
  pid_t                r_gnt;
  pid_t                r_rr_ptr;
  logic                r_app_req;
  logic [APP_AW-1:0]   r_addr;
  logic [BL-1:0]       r_len;
  logic                r_wr_n;
  logic                r_rd_err;

  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_found;
  pid_t                 w_pick;
  logic                 w_full;
  logic                 w_empty;
  pid_t                 w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wr_phase;

  assign w_push     = (r_state == REQ) & app_req_ack & r_wr_n;
  assign w_pop      = app_rd_valid & app_last_rd & ~w_empty;
  assign w_wr_phase = (r_state == WR) | ((r_state == REQ) & ~r_wr_n);

  sdrc_arb_tagq #(
    .DEPTH (RDQ_DEPTH)
  ) u_tagq (
    .clk     (sdram_clk),
    .rst_n   (sdram_resetn),
    .push    (w_push),
    .push_id (r_gnt),
    .pop     (w_pop),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head)
  );

  // Reads are held back while the tag queue cannot record another owner.
  always_comb begin
    w_elig  = p_req & ~p_req_ack & ~(p_req_wr_n & {NUM_PORTS{w_full}});
    w_found = 1'b0;
    w_pick  = '0;
`ifdef SDRC_ARB_PRIO_EN
    if (w_elig[0]) w_found = 1'b1;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + i) % NUM_PORTS]) begin
        w_found = 1'b1;
        w_pick  = pid_t'((int'(r_rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rr_ptr  <= '0;
      r_app_req <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_wr_n    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt     <= w_pick;
            r_app_req <= 1'b1;
            r_addr    <= p_req_addr[int'(w_pick)*APP_AW +: APP_AW];
            r_len     <= p_req_len[int'(w_pick)*BL +: BL];
            r_wr_n    <= p_req_wr_n[int'(w_pick)];
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (app_req_ack) begin
            r_app_req <= 1'b0;
`ifdef SDRC_ARB_PRIO_EN
            if (r_gnt != '0) r_rr_ptr <= pid_inc(r_gnt, NUM_PORTS);
`else
            r_rr_ptr <= pid_inc(r_gnt, NUM_PORTS);
`endif
            r_state <= r_wr_n ? IDLE : WR;
          end
        end
        WR: begin
          if (app_wr_next_req && app_last_wr) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data arriving with no recorded owner is dropped; the flag stays set.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn)              r_rd_err <= 1'b0;
    else if (app_rd_valid && w_empty) r_rd_err <= 1'b1;
  end

  assign app_req      = r_app_req;
  assign app_req_addr = r_addr;
  assign app_req_len  = r_len;
  assign app_req_wr_n = r_wr_n;
  assign p_rd_data    = app_rd_data;

  always_comb begin
    p_req_ack   = '0;
    p_wr_next   = '0;
    p_rd_valid  = '0;
    p_last_rd   = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_gnt == pid_t'(k)) begin
        p_req_ack[k] = (r_state == REQ) & app_req_ack;
        p_wr_next[k] = w_wr_phase & app_wr_next_req;
      end
      if (!w_empty && w_head == pid_t'(k)) begin
        p_rd_valid[k] = app_rd_valid;
        p_last_rd[k]  = app_last_rd;
      end
    end
    if (w_wr_phase) begin
      app_wr_data = p_wr_data[int'(r_gnt)*APP_DW +: APP_DW];
      app_wr_en_n = p_wr_en_n[int'(r_gnt)*APP_BW +: APP_BW];
    end
  end

endmodule

// File: tb/tb_sdrc_mport_arb.sv
// Directed bench for sdrc_mport_arb (4 ports); the bench acts as masters and as the core.
module tb_sdrc_mport_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   p_req;
  logic [103:0] p_req_addr;
  logic [35:0]  p_req_len;
  logic [3:0]   p_req_wr_n;
  logic [3:0]   p_req_ack;
  logic [127:0] p_wr_data;
  logic [15:0]  p_wr_en_n;
  logic [3:0]   p_wr_next;
  logic [31:0]  p_rd_data;
  logic [3:0]   p_rd_valid;
  logic [3:0]   p_last_rd;
  logic         app_req;
  logic [25:0]  app_req_addr;
  logic [8:0]   app_req_len;
  logic         app_req_wr_n;
  logic         app_req_ack;
  logic [31:0]  app_wr_data;
  logic [3:0]   app_wr_en_n;
  logic         app_wr_next_req;
  logic         app_last_wr;
  logic [31:0]  app_rd_data;
  logic         app_rd_valid;
  logic         app_last_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdrc_mport_arb dut (
    .sdram_clk       (clk),
    .sdram_resetn    (rst_n),
    .p_req           (p_req),
    .p_req_addr      (p_req_addr),
    .p_req_len       (p_req_len),
    .p_req_wr_n      (p_req_wr_n),
    .p_req_ack       (p_req_ack),
    .p_wr_data       (p_wr_data),
    .p_wr_en_n       (p_wr_en_n),
    .p_wr_next       (p_wr_next),
    .p_rd_data       (p_rd_data),
    .p_rd_valid      (p_rd_valid),
    .p_last_rd       (p_last_rd),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_ack     (app_req_ack),
    .app_wr_data     (app_wr_data),
    .app_wr_en_n     (app_wr_en_n),
    .app_wr_next_req (app_wr_next_req),
    .app_last_wr     (app_last_wr),
    .app_rd_data     (app_rd_data),
    .app_rd_valid    (app_rd_valid),
    .app_last_rd     (app_last_rd)
  );

  // Core side: wait (bounded) for app_req, accept it, master drops the acked p_req.
  task automatic wait_req(output logic ok, output logic [3:0] ackv,
                          output logic [25:0] addr, output logic wrn);
    ok = 1'b0; ackv = '0; addr = '0; wrn = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (app_req) begin
        app_req_ack = 1'b1;
        #1;
        ackv = p_req_ack;
        addr = app_req_addr;
        wrn  = app_req_wr_n;
        @(posedge clk); #1;
        app_req_ack = 1'b0;
        p_req = p_req & ~ackv;
        ok = 1'b1;
      end
    end
  endtask

  task automatic core_wr(input int beats, input int port, output int n_next,
                         output int n_data, output logic saw_req);
    n_next = 0; n_data = 0; saw_req = 1'b0;
    for (int b = 0; b < beats; b++) begin
      @(posedge clk); #1;
      p_wr_data[port*32 +: 32] = 32'hA000_0000 + b;
      app_wr_next_req = 1'b1;
      app_last_wr     = (b == beats - 1);
      @(negedge clk);
      if (p_wr_next === 4'(1 << port)) n_next++;
      if (app_wr_data === 32'hA000_0000 + b) n_data++;
      saw_req = saw_req | app_req;
    end
    @(posedge clk); #1;
    app_wr_next_req = 1'b0;
    app_last_wr     = 1'b0;
  endtask

  task automatic core_rd(input int beats, output logic [3:0] first_v, output int n_same,
                         output logic [3:0] last_v, output logic [3:0] mid_last,
                         output logic [31:0] first_d);
    first_v = '0; n_same = 0; last_v = '0; mid_last = '0; first_d = '0;
    for (int b = 0; b < beats; b++) begin
      @(posedge clk); #1;
      app_rd_valid = 1'b1;
      app_last_rd  = (b == beats - 1);
      app_rd_data  = 32'hD000 + b;
      @(negedge clk);
      if (b == 0) begin first_v = p_rd_valid; first_d = p_rd_data; end
      if (p_rd_valid === first_v) n_same++;
      if (b == beats - 1) last_v = p_last_rd;
      else mid_last = mid_last | p_last_rd;
    end
    @(posedge clk); #1;
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    p_req = '0; p_req_wr_n = '1; p_wr_data = '0;
    app_req_ack = 0; app_wr_next_req = 0; app_last_wr = 0;
    app_rd_data = '0; app_last_rd = 0; app_rd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p_req_addr[k*26 +: 26] = 26'(32'h1000 * (k + 1));
      p_req_len[k*9 +: 9]    = 9'd4;
      p_wr_en_n[k*4 +: 4]    = 4'(k + 1);
    end
    repeat (3) @(negedge clk);
    checks++; if (app_req !== 1'b0) begin failures++; $display("FAIL reset_app_req got=%b exp=0", app_req); end
    checks++; if (app_wr_en_n !== 4'hF) begin failures++; $display("FAIL reset_wr_en_n got=%h exp=f", app_wr_en_n); end
    checks++; if (p_req_ack !== 4'h0) begin failures++; $display("FAIL reset_req_ack got=%h exp=0", p_req_ack); end
    checks++; if (p_rd_valid !== 4'h0) begin failures++; $display("FAIL reset_rd_valid got=%h exp=0", p_rd_valid); end
    checks++; if (app_req_addr !== 26'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", app_req_addr); end
    @(posedge clk); #1;
    app_rd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reads_all;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    @(posedge clk); #1;
    p_req_wr_n = 4'hF;
    p_req      = 4'hF;
    @(negedge clk);
    checks++; if (app_req !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", app_req); end
    for (int k = 0; k < 4; k++) begin
      wait_req(ok, ackv, addr, wrn);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rd_grant_timeout port=%0d got=%b exp=1", k, ok); end
      checks++; if (ackv !== 4'(1 << k)) begin failures++; $display("FAIL rd_grant_order got=%h exp=%h", ackv, 4'(1 << k)); end
      checks++; if (addr !== 26'(32'h1000 * (k + 1))) begin failures++; $display("FAIL rd_addr got=%h exp=%h", addr, 26'(32'h1000 * (k + 1))); end
      checks++; if (wrn !== 1'b1) begin failures++; $display("FAIL rd_dir got=%b exp=1", wrn); end
    end
    @(negedge clk);
    checks++; if (p_req_ack !== 4'h0) begin failures++; $display("FAIL ack_one_cycle got=%h exp=0", p_req_ack); end
  endtask

  task automatic test_full_queue;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    int n_next, n_data, n_same; logic saw;
    logic [3:0] fv, lv, ml; logic [31:0] fd;
    p_req_wr_n = 4'b1101;
    p_req      = 4'b0011;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0010) begin failures++; $display("FAIL full_wr_grant got=%h exp=2", ackv); end
    checks++; if (wrn !== 1'b0) begin failures++; $display("FAIL full_wr_dir got=%b exp=0", wrn); end
    core_wr(2, 1, n_next, n_data, saw);
    checks++; if (n_next !== 2) begin failures++; $display("FAIL full_wr_next got=%0d exp=2", n_next); end
    checks++; if (n_data !== 2) begin failures++; $display("FAIL full_wr_data got=%0d exp=2", n_data); end
    repeat (3) @(negedge clk);
    checks++; if (app_req !== 1'b0) begin failures++; $display("FAIL full_rd_blocked got=%b exp=0", app_req); end
    core_rd(4, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b0001 || n_same !== 4) begin failures++; $display("FAIL full_pop_valid got=%h/%0d exp=1/4", fv, n_same); end
    checks++; if (lv !== 4'b0001 || ml !== 4'b0) begin failures++; $display("FAIL full_pop_last got=%h/%h exp=1/0", lv, ml); end
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0001) begin failures++; $display("FAIL full_rd_after_pop got=%h exp=1", ackv); end
  endtask

  task automatic test_drain;
    logic [3:0] fv, lv, ml; int n_same; logic [31:0] fd;
    logic [3:0] exp_tag [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      core_rd(4, fv, n_same, lv, ml, fd);
      checks++; if (fv !== exp_tag[i] || n_same !== 4) begin failures++; $display("FAIL drain_valid[%0d] got=%h/%0d exp=%h/4", i, fv, n_same, exp_tag[i]); end
      checks++; if (lv !== exp_tag[i] || ml !== 4'b0) begin failures++; $display("FAIL drain_last[%0d] got=%h/%h exp=%h/0", i, lv, ml, exp_tag[i]); end
    end
    core_rd(1, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b0 || lv !== 4'b0) begin failures++; $display("FAIL empty_drop got=%h/%h exp=0/0", fv, lv); end
  endtask

  task automatic test_write8;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    int n_next, n_data, n_same; logic saw;
    logic [3:0] fv, lv, ml; logic [31:0] fd;
    p_req_len[2*9 +: 9] = 9'd8;
    p_req_wr_n = 4'b1011;
    p_req      = 4'b0101;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0100 || wrn !== 1'b0) begin failures++; $display("FAIL wr8_grant got=%h/%b exp=4/0", ackv, wrn); end
    core_wr(8, 2, n_next, n_data, saw);
    checks++; if (n_next !== 8) begin failures++; $display("FAIL wr8_next got=%0d exp=8", n_next); end
    checks++; if (n_data !== 8) begin failures++; $display("FAIL wr8_data got=%0d exp=8", n_data); end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL wr8_no_grant got=%b exp=0", saw); end
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0001) begin failures++; $display("FAIL wr8_next_grant got=%h exp=1", ackv); end
    core_rd(4, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b0001 || lv !== 4'b0001) begin failures++; $display("FAIL wr8_rd_return got=%h/%h exp=1/1", fv, lv); end
  endtask

  task automatic test_read_return;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    logic [3:0] fv, lv, ml; int n_same; logic [31:0] fd;
    p_req_wr_n = 4'hF;
    p_req      = 4'b0010;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0010) begin failures++; $display("FAIL rr_grant1 got=%h exp=2", ackv); end
    p_req = 4'b1000;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b1000) begin failures++; $display("FAIL rr_grant3 got=%h exp=8", ackv); end
    core_rd(4, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b0010 || n_same !== 4 || lv !== 4'b0010) begin failures++; $display("FAIL ret_port1 got=%h/%0d/%h exp=2/4/2", fv, n_same, lv); end
    checks++; if (fd !== 32'hD000) begin failures++; $display("FAIL ret_data got=%h exp=d000", fd); end
    core_rd(4, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b1000 || n_same !== 4 || lv !== 4'b1000) begin failures++; $display("FAIL ret_port3 got=%h/%0d/%h exp=8/4/8", fv, n_same, lv); end
    core_rd(1, fv, n_same, lv, ml, fd);
    checks++; if (fv !== 4'b0) begin failures++; $display("FAIL ret_empty got=%h exp=0", fv); end
  endtask

  task automatic test_prio;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    int n_next, n_data; logic saw;
`ifdef SDRC_ARB_PRIO_EN
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
`endif
    p_req_wr_n = 4'b1010;
    p_req      = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      wait_req(ok, ackv, addr, wrn);
      p_req = (i < 4) ? 4'b0101 : 4'b0000;
      checks++; if (ackv !== exp_g[i]) begin failures++; $display("FAIL prio_grant[%0d] got=%h exp=%h", i, ackv, exp_g[i]); end
      core_wr(1, ackv[2] ? 2 : 0, n_next, n_data, saw);
    end
  endtask

  task automatic test_reset_mid_wr;
    logic ok; logic [3:0] ackv; logic [25:0] addr; logic wrn;
    p_req_wr_n = 4'b1101;
    p_req      = 4'b1000;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b1000) begin failures++; $display("FAIL rst_pre_rd got=%h exp=8", ackv); end
    p_req = 4'b0010;
    wait_req(ok, ackv, addr, wrn);
    @(posedge clk); #1;
    app_wr_next_req = 1'b1;
    @(negedge clk);
    checks++; if (p_wr_next !== 4'b0010) begin failures++; $display("FAIL rst_pre_wr_next got=%h exp=2", p_wr_next); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (app_req !== 1'b0 || p_wr_next !== 4'b0) begin failures++; $display("FAIL rst_mid_wr got=%b/%h exp=0/0", app_req, p_wr_next); end
    checks++; if (app_wr_en_n !== 4'hF || app_wr_data !== 32'h0) begin failures++; $display("FAIL rst_wr_bus got=%h/%h exp=f/0", app_wr_en_n, app_wr_data); end
    app_wr_next_req = 1'b0;
    app_rd_valid = 1'b1; app_last_rd = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (p_rd_valid !== 4'b0) begin failures++; $display("FAIL rst_queue_empty got=%h exp=0", p_rd_valid); end
    @(posedge clk); #1;
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    p_req_wr_n = 4'hF;
    p_req      = 4'b1001;
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b0001) begin failures++; $display("FAIL rst_rr_ptr got=%h exp=1", ackv); end
    wait_req(ok, ackv, addr, wrn);
    checks++; if (ackv !== 4'b1000) begin failures++; $display("FAIL rst_rr_next got=%h exp=8", ackv); end
  endtask

  initial begin
    test_reset();
    test_reads_all();
    test_full_queue();
    test_drain();
    test_write8();
    test_read_return();
    test_prio();
    test_reset_mid_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
